// File: rtl/sliding_window_fifo_pkg.sv
// Shared helpers for the sliding window FIFO: width computation for
// parameter-dependent pointer and fill counters.
package sliding_window_fifo_pkg;

  // Bits needed to index 'value' distinct states (ceil(log2(value))).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sliding_window_fifo_ram.sv
// Window storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port, so the slot about to be overwritten reads its old value.
module sliding_window_fifo_ram
  import sliding_window_fifo_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sliding_window_fifo.sv
// Fixed-length delay line: data_out is the sample captured DEPTH cycles ago,
// masked to zero until the window has been filled since the last reset.
module sliding_window_fifo
  import sliding_window_fifo_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int FILL_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wptr_reg;
  logic [PTR_W-1:0]  wptr_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              full;
  logic [WIDTH-1:0]  ram_rdata;

  // Full compare at FILL_W bits so a power-of-two DEPTH never aliases to zero.
  assign full = (fill_reg == FILL_W'(DEPTH));

  always_comb begin
    wptr_next = wptr_reg + PTR_W'(1);
    if (wptr_reg == PTR_W'(DEPTH - 1)) begin
      wptr_next = '0;
    end
    fill_next = full ? fill_reg : fill_reg + FILL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg <= '0;
      fill_reg <= '0;
    end else begin
      wptr_reg <= wptr_next;
      fill_reg <= fill_next;
    end
  end

  sliding_window_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (~reset),
    .waddr(wptr_reg),
    .wdata(data_in),
    .raddr(wptr_reg),
    .rdata(ram_rdata)
  );

  // Stale RAM contents stay hidden until DEPTH fresh samples have been written.
  assign data_valid = full;
  assign data_out   = full ? ram_rdata : '0;

endmodule

// File: tb/tb_sliding_window_fifo.sv
// Directed bench for sliding_window_fifo at DEPTH = 4, 5 and 128 sharing one stimulus stream.
module tb_sliding_window_fifo;

  logic        clk;
  logic        reset;
  logic [13:0] data_in;
  logic [13:0] out4, out5, out128;
  logic        valid4, valid5, valid128;

  int vectors;
  int miscompares;

  // Samples captured since the last reset edge, oldest first.
  logic [13:0] hist[$];
  bit          pending;

  sliding_window_fifo #(.WIDTH(14), .DEPTH(4)) d4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(out4), .data_valid(valid4)
  );
  sliding_window_fifo #(.WIDTH(14), .DEPTH(5)) d5 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(out5), .data_valid(valid5)
  );
  sliding_window_fifo #(.WIDTH(14), .DEPTH(128)) d128 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(out128), .data_valid(valid128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_valid(input int depth);
    return hist.size() >= depth;
  endfunction

  function automatic logic [13:0] model_out(input int depth);
    if (hist.size() >= depth) return hist[hist.size() - depth];
    return 14'd0;
  endfunction

  // Record the previous cycle's capture, then drive a new cycle at the falling edge.
  task automatic step(input logic rst, input logic [13:0] v);
    if (pending) begin
      if (reset) hist.delete();
      else hist.push_back(data_in);
    end
    @(negedge clk);
    reset   = rst;
    data_in = v;
    pending = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 14'h1234);
    step(1'b1, 14'h0abc);
    vectors++;
    if (valid4 !== 1'b0 || out4 !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_d4: valid=%b out=%0d, need valid=0 out=0", valid4, out4);
    end
    vectors++;
    if (valid5 !== 1'b0 || out5 !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_d5: valid=%b out=%0d, need valid=0 out=0", valid5, out5);
    end
    vectors++;
    if (valid128 !== 1'b0 || out128 !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_d128: valid=%b out=%0d, need valid=0 out=0", valid128, out128);
    end
    $display("test_reset done");
  endtask

  task automatic test_ramp();
    logic        ev;
    logic [13:0] eo;
    step(1'b1, 14'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 14'(i));
      ev = (i > 4);
      eo = (i > 4) ? 14'(i - 4) : 14'd0;
      vectors++;
      if (valid4 !== ev || out4 !== eo) begin
        miscompares++;
        $display("FAIL ramp_d4[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 i, valid4, out4, ev, eo);
      end
      $display("ramp in=%0d d4 valid=%b out=%0d", i, valid4, out4);
    end
  endtask

  task automatic test_fill_128(input int base);
    logic        ev;
    logic [13:0] eo;
    for (int n = 1; n <= 131; n++) begin
      step(1'b0, 14'((n * 37 + base) & 14'h3fff));
      ev = (n > 128);
      eo = (n > 128) ? 14'(((n - 128) * 37 + base) & 14'h3fff) : 14'd0;
      vectors++;
      if (valid128 !== ev || out128 !== eo) begin
        miscompares++;
        $display("FAIL fill128[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 n, valid128, out128, ev, eo);
      end
      if (n >= 127) $display("fill128 n=%0d valid=%b out=%0d", n, valid128, out128);
    end
  endtask

  task automatic test_wrap5();
    logic [13:0] v;
    step(1'b1, 14'd0);
    for (int n = 1; n <= 20; n++) begin
      v = 14'($urandom_range(0, 16383));
      step(1'b0, v);
      vectors++;
      if (valid5 !== model_valid(5) || out5 !== model_out(5)) begin
        miscompares++;
        $display("FAIL wrap5[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 n, valid5, out5, model_valid(5), model_out(5));
      end
      $display("wrap5 n=%0d in=%0d out=%0d valid=%b", n, v, out5, valid5);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 14'd0);
    for (int n = 1; n <= 200; n++) step(1'b0, 14'(1000 + n));
    vectors++;
    if (valid128 !== 1'b1 || out128 !== 14'd1072) begin
      miscompares++;
      $display("FAIL pre_reset128: valid=%b out=%0d, need valid=1 out=1072", valid128, out128);
    end
    step(1'b1, 14'd7);
    $display("mid-stream reset applied");
    // Fresh stream; exact expectations also prove the old 1000+ data never reappears.
    test_fill_128(5000);
  endtask

  task automatic test_extremes();
    logic [13:0] v;
    step(1'b1, 14'd0);
    for (int n = 1; n <= 14; n++) begin
      v = n[0] ? 14'h3fff : 14'h0000;
      step(1'b0, v);
      vectors++;
      if (valid4 !== model_valid(4) || out4 !== model_out(4)) begin
        miscompares++;
        $display("FAIL extremes_d4[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 n, valid4, out4, model_valid(4), model_out(4));
      end
      vectors++;
      if (valid5 !== model_valid(5) || out5 !== model_out(5)) begin
        miscompares++;
        $display("FAIL extremes_d5[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 n, valid5, out5, model_valid(5), model_out(5));
      end
      $display("extremes n=%0d in=%0d d4=%0d d5=%0d", n, v, out4, out5);
    end
  endtask

  task automatic test_reset_held();
    logic        ev;
    logic [13:0] eo;
    step(1'b0, 14'd9);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k[0] ? 14'h3fff : 14'h1555);
      if (k > 0) begin
        vectors++;
        if (valid4 !== 1'b0 || out4 !== 14'd0) begin
          miscompares++;
          $display("FAIL reset_held[%0d]: valid=%b out=%0d, need valid=0 out=0", k, valid4, out4);
        end
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 14'(100 + i));
      ev = (i > 4);
      eo = (i > 4) ? 14'(100 + i - 4) : 14'd0;
      vectors++;
      if (valid4 !== ev || out4 !== eo) begin
        miscompares++;
        $display("FAIL release_d4[%0d]: valid=%b out=%0d, need valid=%b out=%0d",
                 i, valid4, out4, ev, eo);
      end
      $display("release in=%0d d4 valid=%b out=%0d", 100 + i, valid4, out4);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pending     = 1'b0;
    reset       = 1'b1;
    data_in     = 14'd0;
    test_reset();
    test_ramp();
    step(1'b1, 14'd0);
    test_fill_128(0);
    test_wrap5();
    test_mid_reset();
    test_extremes();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
